// File: rtl/arbitro_soma_10bit.sv
// arbitro_soma_10bit: round-robin arbiter that shares one 10-bit ripple-carry
// adder among four requesters and returns each sum with its requester ID
// over a valid/ready handshake.
// Optional build macro: SOMA_SATURATE_EN clamps the sum to 10'h3FF on carry-out.
module arbitro_soma_10bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [39:0] a_flat,
    input  logic [39:0] b_flat,
    output logic [3:0]  gnt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [9:0]  res_data,
    output logic [1:0]  res_id,
    output logic        res_ovf,
    output logic        busy,
    output logic [15:0] ops_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [9:0]  op_a;
    logic [9:0]  op_b;

    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;
    logic [9:0]  a_sel;
    logic [9:0]  b_sel;

    logic [9:0]  carry;
    logic [9:0]  sum;
    logic        ovf;
    logic [9:0]  sum_out;

    // Round-robin search: scan ptr+1, ptr+2, ptr+3, ptr, taking the first active request
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Operands of the current round-robin winner, captured only at the grant edge
    always_comb begin
        a_sel = a_flat[10*winner +: 10];
        b_sel = b_flat[10*winner +: 10];
    end

    // The single shared ripple-carry adder; carry-in is 0 and the final carry is not built
    always_comb begin
        carry[0] = 1'b0;
        sum      = '0;
        for (int i = 0; i < 10; i++) begin
            sum[i] = op_a[i] ^ op_b[i] ^ carry[i];
            if (i < 9) begin
                carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
            end
        end
    end

    // Overflow is recovered from the wrapped sum, then optionally saturated
    always_comb begin
        ovf = (sum < op_a);
`ifdef SOMA_SATURATE_EN
        sum_out = ovf ? 10'h3FF : sum;
`else
        sum_out = sum;
`endif
    end

    // Arbitration / compute / response sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
            busy      <= 1'b0;
            ops_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (|req) begin
                        op_a  <= a_sel;
                        op_b  <= b_sel;
                        gnt   <= 4'b0001 << winner;
                        ptr   <= winner;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res_data  <= sum_out;
                    res_id    <= ptr;
                    res_ovf   <= ovf;
                    res_valid <= 1'b1;
                    gnt       <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        ops_count <= ops_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_soma_10bit.sv
// tb_arbitro_soma_10bit: directed self-checking bench for the shared-adder arbiter.
// Honours SOMA_SATURATE_EN when computing expected sums.
module tb_arbitro_soma_10bit;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] a_flat;
    logic [39:0] b_flat;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ovf;
    logic        busy;
    logic [15:0] ops_count;

    int checks;
    int failures;
    int expOps;

    arbitro_soma_10bit dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .busy      (busy),
        .ops_count (ops_count)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the request vector and consumer ready
    task automatic applyStimulus(input logic [3:0] r, input logic ready);
        req       = r;
        res_ready = ready;
    endtask

    // Place one requester's operands on the flat buses
    task automatic setOperand(input int i, input logic [9:0] a, input logic [9:0] b);
        a_flat[10*i +: 10] = a;
        b_flat[10*i +: 10] = b;
    endtask

    // Reference sum: wrapped or saturated, as the build selects
    function automatic logic [9:0] expSum(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] full;
        full = {1'b0, a} + {1'b0, b};
`ifdef SOMA_SATURATE_EN
        return full[10] ? 10'h3FF : full[9:0];
`else
        return full[9:0];
`endif
    endfunction

    function automatic logic expOvf(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[10];
    endfunction

    // Synchronous reset for two cycles
    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();
        tick();
        rst    = 1'b0;
        expOps = 0;
    endtask

    logic [3:0] gntSeq [5];
    logic [9:0] opA [4];
    logic [9:0] opB [4];

    initial begin
        checks   = 0;
        failures = 0;
        expOps   = 0;
        a_flat   = '0;
        b_flat   = '0;
        gntSeq   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        opA      = '{10'd100, 10'd500, 10'd1023, 10'd512};
        opB      = '{10'd23,  10'd600, 10'd1,    10'd511};

        // Reset state
        resetDut();
        checkOutput("rst_gnt",   32'(gnt),       32'h0);
        checkOutput("rst_valid", 32'(res_valid), 32'h0);
        checkOutput("rst_busy",  32'(busy),      32'h0);
        checkOutput("rst_ops",   32'(ops_count), 32'h0);
        checkOutput("rst_data",  32'(res_data),  32'h0);
        checkOutput("rst_id",    32'(res_id),    32'h0);
        checkOutput("rst_ovf",   32'(res_ovf),   32'h0);

        // Single request from requester 0: 100 + 23
        setOperand(0, 10'd100, 10'd23);
        applyStimulus(4'b0001, 1'b0);
        tick();
        checkOutput("t1_gnt",   32'(gnt),       32'h1);
        checkOutput("t1_busy",  32'(busy),      32'h1);
        checkOutput("t1_valid0", 32'(res_valid), 32'h0);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("t1_valid", 32'(res_valid), 32'h1);
        checkOutput("t1_data",  32'(res_data),  32'd123);
        checkOutput("t1_id",    32'(res_id),    32'h0);
        checkOutput("t1_ovf",   32'(res_ovf),   32'h0);
        checkOutput("t1_gnt0",  32'(gnt),       32'h0);
        tick();
        checkOutput("t1_done",  32'(res_valid), 32'h0);
        checkOutput("t1_ops",   32'(ops_count), 32'd1);
        checkOutput("t1_idle",  32'(busy),      32'h0);

        // All four requesting: round-robin rotation with a 3-cycle period
        resetDut();
        for (int i = 0; i < 4; i++) setOperand(i, opA[i], opB[i]);
        applyStimulus(4'b1111, 1'b1);
        for (int n = 0; n < 5; n++) begin
            tick();
            checkOutput("rr_gnt",  32'(gnt),  32'(gntSeq[n]));
            checkOutput("rr_busy", 32'(busy), 32'h1);
            tick();
            checkOutput("rr_gnt0",  32'(gnt),       32'h0);
            checkOutput("rr_valid", 32'(res_valid), 32'h1);
            checkOutput("rr_id",    32'(res_id),    32'(n % 4));
            checkOutput("rr_data",  32'(res_data),  32'(expSum(opA[n % 4], opB[n % 4])));
            checkOutput("rr_ovf",   32'(res_ovf),   32'(expOvf(opA[n % 4], opB[n % 4])));
            if (n == 4) applyStimulus(4'b0000, 1'b1);
            tick();
            expOps++;
            checkOutput("rr_hs",  32'(res_valid), 32'h0);
            checkOutput("rr_ops", 32'(ops_count), 32'(expOps));
        end
        tick();
        checkOutput("rr_quiet", 32'(gnt), 32'h0);

        // Back-pressure: ready held low, another request pending
        resetDut();
        setOperand(2, 10'd300, 10'd45);
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("bp_gnt", 32'(gnt), 32'h4);
        applyStimulus(4'b0001, 1'b0);
        tick();
        checkOutput("bp_valid", 32'(res_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("bp_hold_valid", 32'(res_valid), 32'h1);
            checkOutput("bp_hold_data",  32'(res_data),  32'd345);
            checkOutput("bp_hold_id",    32'(res_id),    32'd2);
            checkOutput("bp_hold_gnt",   32'(gnt),       32'h0);
            checkOutput("bp_hold_busy",  32'(busy),      32'h1);
            checkOutput("bp_hold_ops",   32'(ops_count), 32'h0);
        end
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("bp_rel_valid", 32'(res_valid), 32'h0);
        checkOutput("bp_rel_ops",   32'(ops_count), 32'd1);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("bp_once_ops", 32'(ops_count), 32'd1);
        checkOutput("bp_once_gnt", 32'(gnt),       32'h0);

        // Reset while in CALC, then priority restarts from requester 0 side
        resetDut();
        setOperand(0, 10'd7, 10'd8);
        applyStimulus(4'b0001, 1'b0);
        tick();
        checkOutput("rc_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        checkOutput("rc_valid", 32'(res_valid), 32'h0);
        checkOutput("rc_busy",  32'(busy),      32'h0);
        checkOutput("rc_ops",   32'(ops_count), 32'h0);
        checkOutput("rc_gnt0",  32'(gnt),       32'h0);
        setOperand(1, 10'd200, 10'd300);
        setOperand(2, 10'd1,   10'd1);
        applyStimulus(4'b0110, 1'b0);
        tick();
        checkOutput("rc_next_gnt", 32'(gnt), 32'h2);

        // Operands changed after the grant must not affect the result
        applyStimulus(4'b0000, 1'b0);
        a_flat = {4{10'h155}};
        b_flat = {4{10'h0AA}};
        tick();
        checkOutput("cap_data", 32'(res_data), 32'd500);
        checkOutput("cap_id",   32'(res_id),   32'd1);
        checkOutput("cap_ovf",  32'(res_ovf),  32'h0);
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("cap_ops", 32'(ops_count), 32'd1);

        // Ready asserted while idle is ignored
        applyStimulus(4'b0000, 1'b1);
        tick();
        tick();
        checkOutput("idle_ready_ops", 32'(ops_count), 32'd1);
        checkOutput("idle_ready_valid", 32'(res_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
